// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-OpenRAM port-0 bridge.
package sram_bridge_pkg;

  localparam int unsigned WORD_BYTES         = 4;
  localparam int unsigned BYTE_OFF_W         = 2;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StIssue,
    StWait,
    StAck
  } bridge_state_e;

endpackage

// File: rtl/sram_clear_seq.sv
// Address counter for the post-reset zero-fill sweep; done_o sticks until the next reset.
module sram_clear_seq
  import sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  done_o
);

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (en_i && !done_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign addr_o = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/sram_wb_port0_bridge.sv
// Wishbone-classic slave driving port 0 of a 1RW1R OpenRAM macro with registered inputs.
// Single outstanding transaction; optional zero-fill sweep after reset.
module sram_wb_port0_bridge
  import sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_WMASKS     = WORD_BYTES,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wb_cyc_i,
  input  logic                             wb_stb_i,
  input  logic                             wb_we_i,
  input  logic [NUM_WMASKS-1:0]            wb_sel_i,
  input  logic [ADDR_WIDTH+BYTE_OFF_W-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0]            wb_dat_i,
  output logic [DATA_WIDTH-1:0]            wb_dat_o,
  output logic                             wb_ack_o,
  output logic                             busy_o,
  output logic                             sram_csb0,
  output logic                             sram_web0,
  output logic [NUM_WMASKS-1:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0]            sram_addr0,
  output logic [DATA_WIDTH-1:0]            sram_din0,
  input  logic [DATA_WIDTH-1:0]            sram_dout0
);

  bridge_state_e state_q, state_d;

  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;

  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_done;

  // Byte offset bits never reach the word-addressed macro.
  logic unused_adr;
  assign unused_adr = ^wb_adr_i[BYTE_OFF_W-1:0];

  sram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (clr_en),
    .addr_o (clr_addr),
    .done_o (clr_done)
  );

  always_comb begin
    state_d = state_q;
    csb_d   = csb_q;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    clr_en  = 1'b0;

    unique case (state_q)
      StClear: begin
        if (clr_done) begin
          csb_d   = 1'b1;
          web_d   = 1'b1;
          wmask_d = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          clr_en  = 1'b1;
          csb_d   = 1'b0;
          web_d   = 1'b0;
          wmask_d = '1;
          din_d   = '0;
          addr_d  = clr_addr;
        end
      end
      StIdle: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_d  = wb_adr_i[ADDR_WIDTH+BYTE_OFF_W-1:BYTE_OFF_W];
          din_d   = wb_dat_i;
          web_d   = ~wb_we_i;
          wmask_d = wb_we_i ? wb_sel_i : '0;
          csb_d   = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Macro latches the request at the end of this cycle; deselect for the next.
        csb_d = 1'b1;
        web_d = 1'b1;
        if (web_q) begin
          state_d = StWait;
        end else begin
          ack_d   = wb_cyc_i;
          state_d = wb_cyc_i ? StAck : StIdle;
        end
      end
      StWait: begin
        dat_d   = sram_dout0;
        ack_d   = wb_cyc_i;
        state_d = wb_cyc_i ? StAck : StIdle;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? StClear : StIdle;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/sram_wb_port0_bridge.md
# sram_wb_port0_bridge

Wishbone-classic slave that drives the read/write port (port 0) of the 32×256 1RW1R OpenRAM macro and sits directly upstream of it. It converts single bus cycles into the macro's registered-input protocol: active-low chip select, active-low write enable, and byte write mask. It returns read data with a fixed latency. After reset it optionally sweeps the whole array to zero before accepting bus traffic.

## Interface
Parameters:
- ADDR_WIDTH, 8, SRAM word-address width
- DATA_WIDTH, 32, data width
- NUM_WMASKS, 4, byte lanes (DATA_WIDTH/8)
- CLEAR_ON_RESET, 1, 1 = zero-fill all 2^ADDR_WIDTH words after reset

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; the SRAM clk0 is tied to this same net
- rst  in  1  asynchronous, active-high reset
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_sel_i  in  NUM_WMASKS  byte selects
- wb_adr_i  in  ADDR_WIDTH+2  byte address; bits [1:0] ignored
- wb_dat_i  in  DATA_WIDTH  write data
- wb_dat_o  out  DATA_WIDTH  read data, valid with ack
- wb_ack_o  out  1  one-cycle acknowledge
- busy_o  out  1  clear sweep in progress
- sram_csb0  out  1  to macro csb0
- sram_web0  out  1  to macro web0
- sram_wmask0  out  NUM_WMASKS  to macro wmask0
- sram_addr0  out  ADDR_WIDTH  to macro addr0
- sram_din0  out  DATA_WIDTH  to macro din0
- sram_dout0  in  DATA_WIDTH  from macro dout0

## Operation
- All SRAM-side and bus-side outputs are registered.
- Reset values:
  - sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0
  - wb_ack_o=0, wb_dat_o=0
  - busy_o=CLEAR_ON_RESET
- States: CLEAR, IDLE, ISSUE, WAIT, ACK.
- Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- CLEAR:
  - Each cycle drive csb0=0, web0=0, wmask0=all ones, din0=0, addr0=counter; counter increments.
  - After the cycle presenting addr 2^ADDR_WIDTH−1, release csb0=1, clear busy_o, go to IDLE.
  - Bus requests are stalled (no ack) during CLEAR and served afterward.
- IDLE: on cyc&stb, register addr0=wb_adr_i[ADDR_WIDTH+1:2], din0=wb_dat_i, web0=~wb_we_i, wmask0 = wb_we_i ? wb_sel_i : 0, csb0=0; go to ISSUE.
- ISSUE: the macro captures its inputs at the end of this cycle. Drive csb0=1, web0=1. Go to WAIT on a read, or to ACK with wb_ack_o←1 on a write.
- WAIT: at the end of this cycle, wb_dat_o←sram_dout0, wb_ack_o←1; go to ACK.
- ACK: wb_ack_o is high for exactly this cycle, then 0; go to IDLE.
- A write with wb_sel_i=0 is still issued (mask 0) and acked.
- If cyc drops after ISSUE, the SRAM operation still completes, but the ack is suppressed (wb_ack_o←cyc) and the FSM returns to IDLE.
- Reset mid-operation: outputs return to reset values immediately. An in-flight write may or may not land. The clear sweep restarts.

## Timing
- Request sampled at the end of cycle n:
  - Write: ack visible in cycle n+2.
  - Read: ack and data visible in cycle n+3.
  - Next request accepted in cycle n+3 (write) or n+4 (read).
- Read data relies on the macro updating dout0 at negedge + DELAY, so DELAY must be less than half the clock period.
- Back-to-back write then read to the same address returns the new data. The write lands at the negedge of n+2; the read captures its address at the end of n+4.
- Clear sweep takes 2^ADDR_WIDTH cycles (256 at default); busy_o falls on the following edge.
- No pipelining; at most one bus transaction outstanding.

## Structure
- Package sram_bridge_pkg:
  - state enum (CLEAR, IDLE, ISSUE, WAIT, ACK)
  - WORD_BYTES=4 and byte-offset width 2
  - default ADDR_WIDTH and DATA_WIDTH constants
- One natural sub-module, sram_clear_seq:
  - address counter with start and done, driving the clear-phase SRAM inputs
  - muxed with the bus-issue path in the top level

## Test plan
- Reset with CLEAR_ON_RESET=1:
  - busy_o=1 for 256 cycles, sram_addr0 sequences 0x00…0xFF with csb0=0, web0=0, wmask0=4'b1111, din0=0.
  - A later read of any address returns 0x00000000.
- Write adr 0x010, dat 0xDEADBEEF, sel 4'b1111 → ack in cycle n+2. Read adr 0x010 → ack in cycle n+3 with wb_dat_o=0xDEADBEEF.
- Byte-masked write of 0x11223344 with sel 4'b0101 over 0xAAAAAAAA → read returns 0xAA22AA44.
- Request asserted during CLEAR → no ack until busy_o falls, then normal latency and correct data.
- cyc dropped during WAIT → no ack pulse; FSM back to IDLE; the next read completes normally.
- rst asserted during ISSUE → all outputs at reset values that same cycle; sweep restarts from address 0.
